// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - data-memory responder: serialized reads/writes to a word RAM with programmable wait states
module data_memory_responder #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 10,
    parameter int WAIT_STATES  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  address_enable,
    input  logic [DATA_WIDTH-1:0] address,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_done,
    output logic                  busy
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] READ_WAIT  = 2'd1;
    localparam logic [1:0] WRITE_WAIT = 2'd2;
    localparam logic [1:0] DONE       = 2'd3;

    localparam int         DEPTH     = 1 << ADDRESS_BITS;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    logic [1:0]              state_q, state_d;
    logic [3:0]              count_q, count_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    write_done_q, write_done_d;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    // Upper address bits are deliberately dropped so accesses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address[DATA_WIDTH-1:ADDRESS_BITS],
                                write_address[DATA_WIDTH-1:ADDRESS_BITS]};

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        write_done_d = 1'b0;
        mem_we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (write_enable) begin
                    addr_d  = write_address[ADDRESS_BITS-1:0];
                    wdata_d = write_data;
                    count_d = WAIT_INIT;
                    state_d = WRITE_WAIT;
                end else if (address_enable) begin
                    addr_d  = address[ADDRESS_BITS-1:0];
                    count_d = WAIT_INIT;
                    state_d = READ_WAIT;
                end
            end
            READ_WAIT: begin
                if (!address_enable) begin
                    state_d = IDLE;
                end else if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    data_d       = mem_q[addr_q];
                    data_valid_d = 1'b1;
                    state_d      = DONE;
                end
            end
            WRITE_WAIT: begin
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    mem_we       = 1'b1;
                    write_done_d = 1'b1;
                    state_d      = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= 4'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            write_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            write_done_q <= write_done_d;
        end
    end

    // RAM contents survive reset; a reset racing the commit edge still blocks the write.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign data_valid = data_valid_q;
    assign data       = data_q;
    assign write_done = write_done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - scoreboard bench for data_memory_responder (WAIT_STATES=2 and 0 instances)
module tb_data_memory_responder;

    typedef struct {
        int          dut;
        bit          is_wr;
        logic [31:0] val;
        int          edge_n;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        ae     [2];
    logic [31:0] addr   [2];
    logic        dv     [2];
    logic [31:0] rdata  [2];
    logic        we     [2];
    logic [31:0] waddr  [2];
    logic [31:0] wdat   [2];
    logic        wdone  [2];
    logic        busy_s [2];

    int   ws [2] = '{2, 0};
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   busy_cnt [2] = '{0, 0};
    logic prev_dv [2] = '{1'b0, 1'b0};
    exp_t sbq [$];

    data_memory_responder #(.DATA_WIDTH(32), .ADDRESS_BITS(10), .WAIT_STATES(2)) u_ws2 (
        .clock(clock), .reset(reset),
        .address_enable(ae[0]), .address(addr[0]),
        .data_valid(dv[0]), .data(rdata[0]),
        .write_enable(we[0]), .write_address(waddr[0]), .write_data(wdat[0]),
        .write_done(wdone[0]), .busy(busy_s[0])
    );

    data_memory_responder #(.DATA_WIDTH(32), .ADDRESS_BITS(10), .WAIT_STATES(0)) u_ws0 (
        .clock(clock), .reset(reset),
        .address_enable(ae[1]), .address(addr[1]),
        .data_valid(dv[1]), .data(rdata[1]),
        .write_enable(we[1]), .write_address(waddr[1]), .write_data(wdat[1]),
        .write_done(wdone[1]), .busy(busy_s[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    endtask

    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (busy_s[d]) busy_cnt[d]++;
            if (dv[d] && wdone[d]) check("both_pulses", 32'd1, 32'd0);
            if (dv[d]) check("dv_consecutive", 32'(prev_dv[d]), 32'd0);
            prev_dv[d] = dv[d];
            if (dv[d] || wdone[d]) begin
                if (sbq.size() == 0) begin
                    check("spurious_pulse", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("pulse_dut", 32'(d), 32'(e.dut));
                    check("pulse_is_write", 32'(wdone[d]), 32'(e.is_wr));
                    check("pulse_edge", 32'(cyc), 32'(e.edge_n));
                    if (!e.is_wr) check("read_data", rdata[d], e.val);
                end
            end
        end
    end

    task automatic wait_size(input int target, input int budget);
        int n;
        n = 0;
        while (sbq.size() > target && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (sbq.size() > target) begin
            check("response_timeout", 32'(sbq.size()), 32'(target));
            while (sbq.size() > target) void'(sbq.pop_front());
        end
    endtask

    task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] v, output int busy_n);
        int b;
        @(negedge clock);
        #1;
        b = busy_cnt[d];
        we[d] = 1'b1;
        waddr[d] = a;
        wdat[d] = v;
        @(posedge clock);
        #1;
        sbq.push_back('{d, 1'b1, v, cyc + 1 + ws[d]});
        waddr[d] = ~a;
        wdat[d] = ~v;
        wait_size(0, 40);
        we[d] = 1'b0;
        busy_n = busy_cnt[d] - b;
    endtask

    task automatic do_read(input int d, input logic [31:0] a, input logic [31:0] v, output int busy_n);
        int b;
        @(negedge clock);
        #1;
        b = busy_cnt[d];
        ae[d] = 1'b1;
        addr[d] = a;
        @(posedge clock);
        #1;
        sbq.push_back('{d, 1'b0, v, cyc + 1 + ws[d]});
        addr[d] = ~a;
        wait_size(0, 40);
        ae[d] = 1'b0;
        busy_n = busy_cnt[d] - b;
    endtask

    initial begin
        int bn;
        int cap;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            ae[d] = 1'b0; addr[d] = '0; we[d] = 1'b0; waddr[d] = '0; wdat[d] = '0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_data_valid", 32'(dv[d]), 32'd0);
            check("reset_data", rdata[d], 32'd0);
            check("reset_write_done", 32'(wdone[d]), 32'd0);
            check("reset_busy", 32'(busy_s[d]), 32'd0);
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        do_write(0, 32'h10, 32'h0000_00A5, bn);
        check("write_busy_cycles", 32'(bn), 32'd4);
        do_read(0, 32'h10, 32'h0000_00A5, bn);
        check("read_busy_cycles", 32'(bn), 32'd4);

        // Write and read raised together: write first, read captured after DONE.
        @(negedge clock);
        #1;
        we[0] = 1'b1; waddr[0] = 32'h20; wdat[0] = 32'h1234_5678;
        ae[0] = 1'b1; addr[0] = 32'h20;
        @(posedge clock);
        #1;
        cap = cyc;
        sbq.push_back('{0, 1'b1, 32'h1234_5678, cap + 3});
        sbq.push_back('{0, 1'b0, 32'h1234_5678, cap + 8});
        wait_size(1, 40);
        we[0] = 1'b0;
        wait_size(0, 40);
        ae[0] = 1'b0;

        @(negedge clock);
        #1;
        ae[0] = 1'b1; addr[0] = 32'h10;
        @(posedge clock);
        @(negedge clock);
        #1;
        ae[0] = 1'b0;
        repeat (5) @(negedge clock);
        #1;
        check("abort_data_held", rdata[0], 32'h1234_5678);
        check("abort_busy", 32'(busy_s[0]), 32'd0);
        do_read(0, 32'h10, 32'h0000_00A5, bn);

        do_write(0, 32'h0000_0405, 32'hDEAD_BEEF, bn);
        do_read(0, 32'h0000_0005, 32'hDEAD_BEEF, bn);

        do_write(1, 32'h3, 32'h0000_0077, bn);
        check("ws0_write_busy", 32'(bn), 32'd2);
        @(negedge clock);
        #1;
        ae[1] = 1'b1; addr[1] = 32'h3;
        @(posedge clock);
        #1;
        cap = cyc;
        for (int k = 0; k < 3; k++) sbq.push_back('{1, 1'b0, 32'h0000_0077, cap + 1 + 3 * k});
        wait_size(0, 40);
        ae[1] = 1'b0;

        do_write(0, 32'h30, 32'h0, bn);
        @(negedge clock);
        #1;
        we[0] = 1'b1; waddr[0] = 32'h30; wdat[0] = 32'hCAFE_F00D;
        @(posedge clock);
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("midreset_data_valid", 32'(dv[0]), 32'd0);
        check("midreset_data", rdata[0], 32'd0);
        check("midreset_write_done", 32'(wdone[0]), 32'd0);
        check("midreset_busy", 32'(busy_s[0]), 32'd0);
        we[0] = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        do_read(0, 32'h30, 32'h0, bn);

        repeat (6) @(negedge clock);
        #1;
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the pipeline's data-memory protocol.
- Accepts read requests from the read stage (address_enable/address) and returns data_valid/data after a programmable number of wait states.
- Also accepts word writes from the write-back stage (write_enable/write_address/write_data) and acknowledges them with write_done.
- Contains a single-port word-addressed RAM, so only one access is in progress at a time.

Parameters:
- DATA_WIDTH, 32, width of regval_t words.
- ADDRESS_BITS, 10, RAM index width; depth is 2**ADDRESS_BITS words.
- WAIT_STATES, 2, extra cycles between request capture and access; legal range 0..15.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous active-high reset.
- address_enable  in  1  read request from the read stage; held until data_valid or withdrawn.
- address  in  DATA_WIDTH  read word address; only bits [ADDRESS_BITS-1:0] are used.
- data_valid  out  1  one-cycle pulse: data holds the read result.
- data  out  DATA_WIDTH  read result; holds its last value between reads.
- write_enable  in  1  write request; held until write_done.
- write_address  in  DATA_WIDTH  write word address; only low ADDRESS_BITS bits are used.
- write_data  in  DATA_WIDTH  word to store.
- write_done  out  1  one-cycle pulse: write committed.
- busy  out  1  high in every state except IDLE.

Behaviour:
- One clock; reset is asynchronous and active-high (ports clock, reset).
- Reset: data_valid=0, data=0, write_done=0, busy=0, state=IDLE, wait counter=0. RAM contents are not reset.
- States: IDLE, READ_WAIT, WRITE_WAIT, DONE.
- IDLE:
  - write_enable=1: latch write_address/write_data, counter<=WAIT_STATES, go to WRITE_WAIT.
  - Otherwise, address_enable=1: latch address, counter<=WAIT_STATES, go to READ_WAIT.
  - Write has priority when both requests are present.
- READ_WAIT:
  - address_enable=0 (flush/withdraw): abort. Go to IDLE, no data_valid, data unchanged.
  - Else counter!=0: counter<=counter-1.
  - Else counter==0: data<=RAM[latched address], data_valid<=1, go to DONE.
- WRITE_WAIT:
  - counter!=0: counter<=counter-1.
  - counter==0: RAM[latched address]<=latched data, write_done<=1, go to DONE.
  - Writes cannot be aborted; write_enable is ignored after capture.
- DONE: data_valid<=0, write_done<=0, go to IDLE. Requests still asserted in this cycle are ignored, which prevents re-triggering on the stale request.
- Latency: request captured at edge N; response pulse is high from edge N+1+WAIT_STATES to edge N+2+WAIT_STATES. Minimum spacing between request captures is WAIT_STATES+3 edges.
- Address and write_data changes after capture have no effect.
- Upper address bits are ignored, so addresses wrap modulo 2**ADDRESS_BITS.
- A read of a location written by a completed write returns the new value. No bypass is needed because accesses are serialized.
- data_valid and write_done are never high together. Each is high for exactly one cycle per completed access.
- Reset mid-access: access abandoned, no pulse, pending write not committed.

Test Plan:
- Write then read (WAIT_STATES=2): write 0x000000A5 to address 0x10, then read 0x10 → write_done 3 edges after capture; data=0x000000A5 with data_valid high for 1 cycle, 3 edges after read capture; busy high for 4 cycles each.
- Simultaneous requests: write_enable and address_enable raised together (write 0x12345678 to 0x20, read 0x20) → write serviced first; the read is captured after DONE and returns 0x12345678.
- Read abort: address_enable drops one cycle after capture → no data_valid; data keeps its previous value; next read of 0x10 returns 0x000000A5 normally.
- Address wrap (ADDRESS_BITS=10): write 0xDEADBEEF to 0x00000405; read 0x00000005 → data=0xDEADBEEF.
- WAIT_STATES=0: read held continuously across three back-to-back requests → data_valid at edges N+1, N+4, N+7; data_valid is never high on consecutive cycles.
- Reset mid-write: assert reset during WRITE_WAIT of 0xCAFEF00D to 0x30 → all outputs immediately 0, no write_done; later read of 0x30 does not return 0xCAFEF00D (location previously written with 0x0).
